// File: rtl/pll_lock_supervisor_pkg.sv
// Shared clock/reset definitions: FSM state encoding and default hold times.
package pll_lock_supervisor_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } pll_state_e;

    localparam int unsigned DEFAULT_LOCK_HOLD  = 1024;
    localparam int unsigned DEFAULT_RESET_HOLD = 16;

    // Larger of two unsigned values, used to size the shared hold counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low clear to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; bit 0 is the first stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL lock flag and generates the glitch-free system reset.
// rst_out only deasserts after lock_s has been high for LOCK_HOLD consecutive
// cycles; every loss of lock in RUN holds reset for at least RESET_HOLD cycles
// and bumps a saturating loss counter.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_HOLD   = DEFAULT_LOCK_HOLD,
    parameter int unsigned RESET_HOLD  = DEFAULT_RESET_HOLD,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lock_in,
    input  logic             clear_count,
    output logic             rst_out,
    output logic             ready,
    output logic             loss_pulse,
    output logic [CNT_W-1:0] loss_count
);

    localparam int unsigned HOLD_W = $clog2(max_u(LOCK_HOLD, RESET_HOLD) + 1);
    localparam logic [HOLD_W-1:0] LOCK_LAST  = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [HOLD_W-1:0] RESET_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  LOSS_ONE   = CNT_W'(1);

    logic              lock_s;
    pll_state_e        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              rst_q, rst_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0]  loss_base;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (lock_in),
        .q_o   (lock_s)
    );

    // Next-state logic: qualify lock, run, and stretch reset after a loss.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = QUALIFY;
                    cnt_d   = '0;
                end
            end
            QUALIFY: begin
                // Any dropout restarts qualification from zero.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HOLD_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end
            end
            HOLD: begin
                // Reset stretch ignores lock_s entirely.
                if (cnt_q == RESET_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values: reset from the next state, loss counter with clear-then-count.
    always_comb begin
        rst_d      = (state_d != RUN);
        loss_base  = clear_count ? '0 : loss_cnt_q;
        loss_cnt_d = loss_base;
        if (pulse_d && (loss_base != {CNT_W{1'b1}})) begin
            loss_cnt_d = loss_base + LOSS_ONE;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            rst_q      <= 1'b1;
            pulse_q    <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_q      <= rst_d;
            pulse_q    <= pulse_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign rst_out    = rst_q;
    assign ready      = !rst_q;
    assign loss_pulse = pulse_q;
    assign loss_count = loss_cnt_q;

endmodule
